// File: rtl/alu_issue_seq.sv
// Issue-side sequencer for the 16-bit ALU: owns an 8-entry register file and steps one
// instruction at a time through IDLE/OPRD/EXEC/WB. Optional macro: ALU_SEQ_IMM_EN.
module alu_issue_seq #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned FLAG_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [15:0]       instr,
   output logic [DATA_W-1:0] alu_data_in_1,
   output logic [DATA_W-1:0] alu_data_in_2,
   output logic [1:0]        alu_op,
   input  logic [DATA_W-1:0] alu_data_out,
   input  logic              alu_z_flag,
   input  logic              alu_a_grt_b,
   input  logic              alu_b_grt_a,
   input  logic              rf_wr_en,
   input  logic [2:0]        rf_wr_addr,
   input  logic [DATA_W-1:0] rf_wr_data,
   input  logic [2:0]        dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   output logic              wb_valid,
   output logic [2:0]        wb_addr,
   output logic [DATA_W-1:0] wb_data,
   output logic [FLAG_W-1:0] flags,
   output logic              busy
);

   typedef enum logic [1:0] {StIdle, StOprd, StExec, StWb} state_t;

   state_t            state_q;
   logic [1:0]        op_q;
   logic [2:0]        rd_q;
   logic [2:0]        rs1_q;
   logic [2:0]        rs2_q;
   logic              imm_sel_q;
   logic [DATA_W-1:0] result_q;
   logic [FLAG_W-1:0] flag_shadow_q;
   logic [DATA_W-1:0] rf_q [8];

   logic [DATA_W-1:0] opnd_a;
   logic [DATA_W-1:0] opnd_b;
   logic              unused_bits;

   assign unused_bits = ^{instr[13:12], instr[1:0], imm_sel_q};

   assign instr_ready = (state_q == StIdle);
   assign busy        = (state_q != StIdle);
   assign dbg_data    = (dbg_addr == 3'd0) ? '0 : rf_q[dbg_addr];

   // An external write landing on the OPRD edge is forwarded so the operand sees it.
   always_comb begin
      opnd_a = '0;
      opnd_b = '0;
      if (rs1_q != 3'd0) begin
         opnd_a = (rf_wr_en && rf_wr_addr == rs1_q) ? rf_wr_data : rf_q[rs1_q];
      end
      if (rs2_q != 3'd0) begin
         opnd_b = (rf_wr_en && rf_wr_addr == rs2_q) ? rf_wr_data : rf_q[rs2_q];
      end
`ifdef ALU_SEQ_IMM_EN
      if (imm_sel_q) begin
         opnd_b = {{(DATA_W-3){1'b0}}, rs2_q};
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         op_q          <= 2'b00;
         rd_q          <= 3'd0;
         rs1_q         <= 3'd0;
         rs2_q         <= 3'd0;
         imm_sel_q     <= 1'b0;
         result_q      <= '0;
         flag_shadow_q <= '0;
         alu_data_in_1 <= '0;
         alu_data_in_2 <= '0;
         alu_op        <= 2'b00;
         wb_valid      <= 1'b0;
         wb_addr       <= 3'd0;
         wb_data       <= '0;
         flags         <= '0;
         for (int i = 0; i < 8; i++) begin
            rf_q[i] <= '0;
         end
      end else begin
         wb_valid <= 1'b0;
         if (rf_wr_en && rf_wr_addr != 3'd0) begin
            rf_q[rf_wr_addr] <= rf_wr_data;
         end
         unique case (state_q)
            StIdle: begin
               if (instr_valid) begin
                  op_q      <= instr[15:14];
                  rd_q      <= instr[11:9];
                  rs1_q     <= instr[8:6];
                  rs2_q     <= instr[5:3];
                  imm_sel_q <= instr[2];
                  state_q   <= StOprd;
               end
            end
            StOprd: begin
               alu_data_in_1 <= opnd_a;
               alu_data_in_2 <= opnd_b;
               alu_op        <= op_q;
               state_q       <= StExec;
            end
            StExec: begin
               result_q      <= alu_data_out;
               flag_shadow_q <= {alu_b_grt_a, alu_a_grt_b, alu_z_flag};
               state_q       <= StWb;
            end
            StWb: begin
               // Placed after the external write so writeback wins a same-register collision.
               if (rd_q != 3'd0) begin
                  rf_q[rd_q] <= result_q;
               end
               wb_valid <= 1'b1;
               wb_addr  <= rd_q;
               wb_data  <= result_q;
               flags    <= flag_shadow_q;
               state_q  <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
